// File: rtl/fetch_queue_if.sv
// IF/ID handshake bundle for the fetch queue: push side from IF, pop side and
// head presentation to ID, plus flush and occupancy status.
interface fetch_queue_if #(
  parameter int PTR_W = 3
);
  logic             FLUSH;
  logic             Push_IN;
  logic [31:0]      Instr1_IN;
  logic [31:0]      Instr_PC_IN;
  logic             Pop_IN;
  logic [31:0]      Instr1_OUT;
  logic [31:0]      Instr_PC_OUT;
  logic [31:0]      Instr_PC_Plus4;
  logic             Valid_OUT;
  logic             STALL_OUT;
  logic [PTR_W:0]   Count_OUT;

  modport master (
    output FLUSH, Push_IN, Instr1_IN, Instr_PC_IN, Pop_IN,
    input  Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Valid_OUT, STALL_OUT, Count_OUT
  );

  modport slave (
    input  FLUSH, Push_IN, Instr1_IN, Instr_PC_IN, Pop_IN,
    output Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Valid_OUT, STALL_OUT, Count_OUT
  );
endinterface

// File: rtl/fetch_queue.sv
// First-word-fall-through instruction queue between IF and ID; head entry is
// presented combinationally, IF is back-pressured when full, FLUSH empties it.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  fetch_queue_if.slave  fq
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             pop_ok;
  logic             push_ok;
  logic [63:0]      head_entry;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = fq.Pop_IN && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = fq.Push_IN && (!full || pop_ok);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (fq.FLUSH) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop_ok)  head <= head + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; reset and flush only suppress the write.
  always_ff @(posedge CLK) begin
    if (RESET && !fq.FLUSH && push_ok)
      mem[tail] <= {fq.Instr1_IN, fq.Instr_PC_IN};
  end

  assign head_entry        = empty ? 64'h0 : mem[head];
  assign fq.Instr1_OUT     = head_entry[63:32];
  assign fq.Instr_PC_OUT   = head_entry[31:0];
  assign fq.Instr_PC_Plus4 = empty ? 32'h0 : (head_entry[31:0] + 32'd4);
  assign fq.Valid_OUT      = !empty;
  assign fq.STALL_OUT      = full;
  assign fq.Count_OUT      = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic CLK;
  logic RESET;
  fetch_queue_if #(.PTR_W(PTR_W)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .fq    (fq)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  logic [63:0] model_q [$];
  bit armed = 1'b0;

  // Reference model: the queue contents after each rising edge.
  always @(posedge CLK) begin
    bit pop_m, push_m;
    if (!RESET) begin
      model_q.delete();
      armed = 1'b1;
    end else if (fq.FLUSH) begin
      model_q.delete();
    end else begin
      pop_m  = fq.Pop_IN && (model_q.size() != 0);
      push_m = fq.Push_IN && ((model_q.size() != DEPTH) || pop_m);
      if (pop_m)  void'(model_q.pop_front());
      if (push_m) model_q.push_back({fq.Instr1_IN, fq.Instr_PC_IN});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    logic [31:0] ei, ep, e4;
    int n;
    if (armed) begin
      n  = model_q.size();
      ei = (n != 0) ? model_q[0][63:32] : 32'h0;
      ep = (n != 0) ? model_q[0][31:0]  : 32'h0;
      e4 = (n != 0) ? ep + 32'd4        : 32'h0;
      chk("model_count", 32'(fq.Count_OUT), n);
      chk("model_valid", 32'(fq.Valid_OUT), (n != 0) ? 32'd1 : 32'd0);
      chk("model_stall", 32'(fq.STALL_OUT), (n == DEPTH) ? 32'd1 : 32'd0);
      chk("model_instr", fq.Instr1_OUT, ei);
      chk("model_pc",    fq.Instr_PC_OUT, ep);
      chk("model_pc4",   fq.Instr_PC_Plus4, e4);
    end
  end

  task automatic step(input bit rst_n, input bit flush, input bit push, input bit pop,
                      input logic [31:0] instr, input logic [31:0] pc);
    RESET          = rst_n;
    fq.FLUSH       = flush;
    fq.Push_IN     = push;
    fq.Pop_IN      = pop;
    fq.Instr1_IN   = instr;
    fq.Instr_PC_IN = pc;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    RESET = 1'b0; fq.FLUSH = 1'b0; fq.Push_IN = 1'b0; fq.Pop_IN = 1'b0;
    fq.Instr1_IN = '0; fq.Instr_PC_IN = '0;

    // Reset held with a push request.
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFE0000, 32'h100);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFE0001, 32'h104);
    chk("rst_valid", 32'(fq.Valid_OUT), 32'd0);
    chk("rst_stall", 32'(fq.STALL_OUT), 32'd0);
    chk("rst_count", 32'(fq.Count_OUT), 32'd0);
    chk("rst_instr", fq.Instr1_OUT, 32'h0);
    idle();
    chk("post_rst_count", 32'(fq.Count_OUT), 32'd0);

    // Fill, overflow attempt, drain.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h20000000 + i, 32'h400000 + 4*i);
    chk("fill_count", 32'(fq.Count_OUT), 32'd8);
    chk("fill_stall", 32'(fq.STALL_OUT), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h999);
    chk("drop_count", 32'(fq.Count_OUT), 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_instr", fq.Instr1_OUT, 32'h20000000 + i);
      chk("drain_pc4", fq.Instr_PC_Plus4, 32'h400004 + 4*i);
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    end
    chk("drain_valid", 32'(fq.Valid_OUT), 32'd0);

    // Simultaneous push/pop at full.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h30000000 + i, 32'h600000 + 4*i);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h11111111, 32'h700000);
    chk("pp_count", 32'(fq.Count_OUT), 32'd8);
    chk("pp_head", fq.Instr1_OUT, 32'h30000001);
    repeat (7) step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("pp_new_head", fq.Instr1_OUT, 32'h11111111);
    chk("pp_new_pc4", fq.Instr_PC_Plus4, 32'h700004);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Wrap-around of both pointers.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h40000000 + i, 32'h800000 + 4*i);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h50000000 + i, 32'h900000 + 4*i);
    for (int i = 0; i < 6; i++) begin
      chk("wrap_pc", fq.Instr_PC_OUT, 32'h900000 + 4*i);
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    end

    // Flush beats push and pop in the same cycle.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h60000000 + i, 32'hA00000 + 4*i);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h77777777, 32'hB00000);
    chk("flush_count", 32'(fq.Count_OUT), 32'd0);
    chk("flush_valid", 32'(fq.Valid_OUT), 32'd0);
    chk("flush_instr", fq.Instr1_OUT, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'h400100);
    chk("flush_push_pc4", fq.Instr_PC_Plus4, 32'h400104);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Pops while empty are ignored.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("empty_pop_count", 32'(fq.Count_OUT), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000AAAA, 32'hFFFFFFFC);
    chk("pc4_wrap", fq.Instr_PC_Plus4, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000BBBB, 32'h10);
    chk("after_pp_head", fq.Instr1_OUT, 32'h0000BBBB);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Randomized traffic with occasional flush and mid-stream reset.
    for (int c = 0; c < 3000; c++) begin
      int mode;
      bit psh, pp;
      mode = int'($urandom_range(0, 3));
      psh = ($urandom_range(0, 99) < (mode == 0 ? 80 : (mode == 1 ? 20 : 55)));
      pp  = ($urandom_range(0, 99) < (mode == 0 ? 20 : (mode == 1 ? 80 : 50)));
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 79) == 0), psh, pp,
           $urandom(), $urandom());
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue between IF and ID; replaces the fixed-length pass-through delay chain.
- Buffers fetched {instruction, PC} pairs in a first-word-fall-through FIFO.
- Presents the head entry to ID and back-pressures IF when full.
- Discards all contents on a BTB/branch-resolution FLUSH.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- PTR_W, 3, log2(DEPTH); pointer width. Count width is PTR_W+1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-low reset.
- FLUSH  input  1  discard all entries this cycle.
- Push_IN  input  1  IF presents a valid fetched instruction.
- Instr1_IN  input  32  instruction word from IF.
- Instr_PC_IN  input  32  PC of Instr1_IN.
- Pop_IN  input  1  ID consumes the head entry; this is ID not stalling.
- Instr1_OUT  output  32  head instruction; 32'h0 (NOP) when empty.
- Instr_PC_OUT  output  32  head PC; 32'h0 when empty.
- Instr_PC_Plus4  output  32  Instr_PC_OUT + 4; 32'h0 when empty.
- Valid_OUT  output  1  queue non-empty; head outputs meaningful.
- STALL_OUT  output  1  queue full; IF must hold its PC.
- Count_OUT  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 64-bit {instr, PC} array, plus registered head ptr, tail ptr and count. The array is not reset.
- Reset (RESET==0 at posedge): head=0, tail=0, count=0.
  - Resulting outputs: Valid_OUT=0, STALL_OUT=0, Count_OUT=0; Instr1_OUT, Instr_PC_OUT and Instr_PC_Plus4 are 0.
  - Reset overrides FLUSH, push and pop.
  - Reset mid-operation drops all entries with no partial writes.
- Head outputs are combinational reads of array[head], gated to 0 when count==0. Zero-latency FWFT: an entry pushed at edge N is visible at outputs after edge N.
- Valid_OUT = (count != 0). STALL_OUT = (count == DEPTH). Count_OUT = count. All are derived from registered state only; no combinational path from Push_IN or Pop_IN.
- Effective pop: pop_ok = Pop_IN && count != 0. Pop_IN while empty is ignored.
- Effective push: push_ok = Push_IN && (count != DEPTH || pop_ok).
  - Push accepted while full when a pop occurs in the same cycle.
  - Push_IN while full with no pop is dropped. IF must not assert it, because it sees STALL_OUT.
- Update priority: RESET > FLUSH > push/pop.
  - FLUSH=1: head=0, tail=0, count=0; push and pop in the same cycle are both discarded. Valid_OUT=0 from the next cycle.
  - push_ok: array[tail] <= {Instr1_IN, Instr_PC_IN}; tail <= tail+1.
  - pop_ok: head <= head+1.
  - count <= count + push_ok - pop_ok, so a simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo DEPTH (natural PTR_W-bit overflow); count never exceeds DEPTH and never goes below 0.
- Push and pop on the same entry is not possible when empty, since pop_ok=0 at count 0. No bypass: an instruction cannot pass through in zero cycles.
- Instr_PC_Plus4 uses 32-bit wrapping addition; overflow is ignored.
- Ordering: strict FIFO; entries leave in push order.

Test Plan:
- Reset: hold RESET=0 for 2 cycles with Push_IN=1 -> Valid_OUT=0, STALL_OUT=0, Count_OUT=0, Instr1_OUT=0. Release reset -> still empty until the first push edge.
- Fill/drain: push 8 entries (instr 0x20000000+i, PC 0x400000+4i) with Pop_IN=0 -> Count_OUT=8 and STALL_OUT=1 after the 8th edge.
  - A 9th push (Push_IN=1, instr 0xDEADBEEF) is dropped.
  - Pop 8 times -> heads appear in order 0x20000000..0x20000007 with Instr_PC_Plus4=PC+4; Valid_OUT=0 after the last pop.
- Simultaneous push/pop: at full, Push_IN=Pop_IN=1 with instr 0x11111111 -> count stays 8, head advances, and the new entry emerges after 7 more pops.
- Wrap-around: push 5, pop 5, push 6 -> tail wraps past index 7; the 6 entries pop in order with correct PCs.
- Flush: with count=4, assert FLUSH together with Push_IN=1 and Pop_IN=1 -> next cycle count=0, Valid_OUT=0, Instr1_OUT=0. A following push of PC 0x400100 appears at head with Instr_PC_Plus4=0x400104.
- Empty pop: Pop_IN=1 with count=0 for 3 cycles -> Count_OUT stays 0. A subsequent push/pop sequence returns data in correct order.
